// File: rtl/bintodec_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bintodec_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    input  logic       unused_tie,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one bit per cycle, result
// published on a registered bcd bus together with a one-cycle done pulse.
module bin2bcd_seq
    import bintodec_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t              state, state_nx;
    logic [WIDTH-1:0]    sr;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                load;
    logic                shift_en;
    logic                finish;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch[4*i +: 4]),
            .unused_tie(1'b0),
            .digit_out (adj[4*i +: 4])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt <= CW'(1)) state_nx = DONE;
            end
            DONE: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // bcd only changes on finish, so downstream logic never sees partial scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= finish;
            busy <= (state == SHIFT);
            if (load) begin
                sr      <= bin;
                scratch <= '0;
                cnt     <= CW'(WIDTH);
            end else if (shift_en) begin
                scratch <= {adj[4*DIGITS-2:0], sr[WIDTH-1]};
                sr      <= {sr[WIDTH-2:0], 1'b0};
                cnt     <= cnt - CW'(1);
            end
            if (finish) bcd <= scratch;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner values, continuous start,
// mid-conversion reset and a full 0..255 sweep against an arithmetic reference.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    bin   = '0;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;

    int               n_vec   = 0;
    int               n_err   = 0;
    logic [11:0]      exp_bcd = '0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .bcd  (bcd)
    );

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full conversion: start sampled at edge 0, result checked after edge 9.
    // start and bin are scrambled while the block is busy to show they are ignored.
    task automatic run_conv(input logic [WIDTH-1:0] v);
        start = 1'b1;
        bin   = v;
        step();
        check("accept_busy", 32'(busy), 0);
        check("accept_done", 32'(done), 0);
        for (int k = 1; k <= WIDTH; k++) begin
            start = 1'($urandom_range(0, 1));
            bin   = WIDTH'($urandom);
            step();
            check("shift_busy", 32'(busy), 1);
            check("shift_done", 32'(done), 0);
            check("bcd_hold", 32'(bcd), 32'(exp_bcd));
        end
        start = 1'($urandom_range(0, 1));
        bin   = WIDTH'($urandom);
        step();
        exp_bcd = ref_bcd(int'(v));
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("result", 32'(bcd), 32'(exp_bcd));
        check("digit_range", 32'(bcd[3:0] <= 4'd9 && bcd[7:4] <= 4'd9 && bcd[11:8] <= 4'd9), 1);
        start = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] bin_at [0:39];
        int               next_accept;
        int               due;

        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bcd", 32'(bcd), 0);
        step();
        step();
        rst_n = 1'b1;

        // First start right after reset release, bin = 0.
        run_conv(8'd0);
        step();
        check("done_width", 32'(done), 0);

        run_conv(8'd255);
        run_conv(8'd99);
        run_conv(8'd100);
        run_conv(8'd9);

        // start held high with bin changing every cycle.
        next_accept = 0;
        due         = -1;
        start       = 1'b1;
        for (int t = 0; t < 40; t++) begin
            bin       = WIDTH'($urandom);
            bin_at[t] = bin;
            step();
            if (t == next_accept) begin
                due         = t + WIDTH + 1;
                next_accept = t + WIDTH + 2;
            end
            if (t == due) begin
                exp_bcd = ref_bcd(int'(bin_at[t - WIDTH - 1]));
                check("cont_done", 32'(done), 1);
                check("cont_result", 32'(bcd), 32'(exp_bcd));
            end else begin
                check("cont_no_done", 32'(done), 0);
            end
            check("cont_excl", 32'(busy & done), 0);
        end
        start = 1'b0;

        // Reset in the middle of a bin=200 conversion.
        run_conv(8'd123);
        start = 1'b1;
        bin   = 8'd200;
        step();
        start = 1'b0;
        for (int k = 1; k < 4; k++) step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bcd", 32'(bcd), 0);
        step();
        rst_n   = 1'b1;
        exp_bcd = '0;
        for (int k = 0; k < WIDTH + 2; k++) begin
            step();
            check("abort_no_done", 32'(done), 0);
            check("abort_idle", 32'(busy), 0);
            check("abort_bcd_hold", 32'(bcd), 0);
        end
        run_conv(8'd37);

        // Back-to-back sweep of every input value.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            run_conv(WIDTH'(v));
        end
        step();
        check("final_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the binary input. The design is verified only at the default.
REQ-002 The block SHALL have parameter DIGITS, default 3: number of BCD output digits. DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port bin, input, WIDTH bits: unsigned binary operand, sampled together with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when bcd is updated.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: registered result. Hundreds digit is [11:8], tens is [7:4], ones is [3:0].

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1, the block SHALL capture bin into a shift register, clear the BCD scratch to zero, load the bit counter with WIDTH, go to SHIFT and assert busy from the next cycle.
REQ-012 Each SHIFT cycle SHALL first add 3 to every scratch digit that is >= 5, then shift {scratch, shift register} left by one, then decrement the counter.
REQ-013 When the counter reaches zero at the end of a SHIFT cycle, the block SHALL go to DONE.
REQ-014 In DONE, the block SHALL copy the scratch into bcd, assert done for exactly one cycle, deassert busy and return to IDLE.
REQ-015 Latency SHALL be WIDTH+1 cycles: with start sampled at edge 0, done and the new bcd are visible after edge WIDTH+1 (edge 9 for WIDTH=8).
REQ-016 start SHALL be ignored in SHIFT and DONE; bin changes after capture SHALL have no effect.
REQ-017 A start sampled in the cycle immediately after DONE (back in IDLE) SHALL be accepted; the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-018 bcd SHALL hold its last value between completions and SHALL never show partial scratch contents.
REQ-019 Every output digit SHALL be in the range 0..9 for any bin in 0..2^WIDTH-1.
REQ-020 busy and done SHALL never be high in the same cycle.

Reset
REQ-021 When rst_n=0, the block SHALL force state to IDLE, busy=0, done=0, bcd=0, counter=0, scratch=0 and shift register=0, regardless of clk.
REQ-022 A reset asserted mid-conversion SHALL abort the conversion with no done pulse.
REQ-023 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-024 Shared package bintodec_pkg SHALL hold the FSM state typedef and the constants WIDTH_DEF=8 and DIGITS_DEF=3.
REQ-025 The add-3 step SHALL be a combinational sub-module bcd_digit_adj (4-bit in, 4-bit out: out = in>=5 ? in+3 : in), instantiated DIGITS times.
REQ-026 The bcd output SHALL connect directly to the x/y data inputs of the downstream 8-bit 2:1 selector (low two digits).

Verification
REQ-027 bin=0, start pulse -> done at edge 9, bcd=12'h000, busy high for edges 1..8.
REQ-028 bin=255 -> bcd=12'h255; bin=99 -> 12'h099; bin=100 -> 12'h100; bin=9 -> 12'h009.
REQ-029 start held high continuously with bin changing every cycle -> each result equals the bin sampled at its accepted start; conversions spaced exactly 10 cycles apart.
REQ-030 rst_n pulsed low at edge 4 of a bin=200 conversion -> no done pulse, bcd=0, busy=0; a new start with bin=37 -> bcd=12'h037.
REQ-031 Exhaustive sweep of bin=0..255 against a reference model -> every digit in 0..9, done exactly one cycle wide and never coincident with busy.
